// File: rtl/wb_if.sv
// MEM-to-writeback result handshake bundle.
interface wb_if;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_rd;
  logic        m_is_load;
  logic [1:0]  m_ld_size;
  logic        m_ld_signed;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu;
  logic [31:0] m_mem;

  modport master (
    output m_valid, m_rd, m_is_load, m_ld_size,
    output m_ld_signed, m_addr_lo, m_alu, m_mem,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_rd, m_is_load, m_ld_size,
    input  m_ld_signed, m_addr_lo, m_alu, m_mem,
    output m_ready
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback buffer: in-order result queue driving the register-file write port.
// Bypass lookup is built only when WB_UNIT_FWD_EN is defined.
module wb_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  wb_if.slave         m,
  input  logic        wr_hold,
  output logic        WB,
  output logic [4:0]  Rd,
  output logic [31:0] reg_s,
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_data,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_q  [DEPTH];
  logic [31:0]   val_q [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   value;

  function automatic logic [31:0] load_fmt(
    input logic [1:0]  size,
    input logic        sgn,
    input logic [1:0]  lo,
    input logic [31:0] mem
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = mem[31:24];
      2'd1:    b = mem[23:16];
      2'd2:    b = mem[15:8];
      default: b = mem[7:0];
    endcase
    h = lo[1] ? mem[15:0] : mem[31:16];
    if (size == 2'b00)
      return {{24{sgn & b[7]}}, b};
    else if (size == 2'b01)
      return {{16{sgn & h[15]}}, h};
    else
      return mem;
  endfunction

  assign full      = (cnt == CW'(DEPTH));
  assign m.m_ready = ~reset & ~full;
  assign accept    = m.m_valid & m.m_ready;
  assign push      = accept & (m.m_rd != 5'd0);
  assign pop       = (cnt != '0) & ~wr_hold;
  assign value     = m.m_is_load
                   ? load_fmt(m.m_ld_size, m.m_ld_signed,
                              m.m_addr_lo, m.m_mem)
                   : m.m_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      WB    <= 1'b0;
      Rd    <= 5'd0;
      reg_s <= 32'd0;
    end else begin
      WB <= pop;
      if (pop) begin
        Rd    <= rd_q[rptr];
        reg_s <= val_q[rptr];
        rptr  <= rptr + 1'b1;
      end
      if (push) begin
        rd_q[wptr]  <= m.m_rd;
        val_q[wptr] <= value;
        wptr        <= wptr + 1'b1;
      end
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

`ifdef WB_UNIT_FWD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd1_hit  = WB && (Rd == fwd_rs1);
    fwd1_data = fwd1_hit ? reg_s : 32'd0;
    fwd2_hit  = WB && (Rd == fwd_rs2);
    fwd2_data = fwd2_hit ? reg_s : 32'd0;
    idx       = rptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < cnt) begin
        if (rd_q[idx] == fwd_rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = val_q[idx];
        end
        if (rd_q[idx] == fwd_rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = val_q[idx];
        end
      end
    end
    if (fwd_rs1 == 5'd0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = 32'd0;
    end
    if (fwd_rs2 == 5'd0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = 32'd0;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs1, fwd_rs2};
  assign fwd1_hit   = 1'b0;
  assign fwd1_data  = 32'd0;
  assign fwd2_hit   = 1'b0;
  assign fwd2_data  = 32'd0;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Randomised check of wb_unit against a queue-based reference model,
// plus directed literal scenarios.
module tb_wb_unit;
  localparam int DEPTH = 2;
`ifdef WB_UNIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_hold;
  logic        WB;
  logic [4:0]  Rd;
  logic [31:0] reg_s;
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;

  wb_if bus ();

  wb_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .m         (bus.slave),
    .wr_hold   (wr_hold),
    .WB        (WB),
    .Rd        (Rd),
    .reg_s     (reg_s),
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
  } ent_t;

  ent_t        q[$];
  logic        mwb;
  logic [4:0]  mrd;
  logic [31:0] mval;
  int          total = 0;
  int          bad   = 0;

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt();
    int unsigned sh;
    logic [31:0] x;
    if (!bus.m_is_load) return bus.m_alu;
    if (bus.m_ld_size == 2'b00) begin
      sh = 24 - 8 * int'(bus.m_addr_lo);
      x  = (bus.m_mem >> sh) & 32'hFF;
      if (bus.m_ld_signed && x[7]) x = x | 32'hFFFF_FF00;
      return x;
    end
    if (bus.m_ld_size == 2'b01) begin
      sh = bus.m_addr_lo[1] ? 0 : 16;
      x  = (bus.m_mem >> sh) & 32'hFFFF;
      if (bus.m_ld_signed && x[15]) x = x | 32'hFFFF_0000;
      return x;
    end
    return bus.m_mem;
  endfunction

  function automatic logic model_ready();
    return !reset && (q.size() < DEPTH);
  endfunction

  function automatic logic [32:0] model_fwd(logic [4:0] rs);
    if (!FWD || rs == 5'd0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rs) return {1'b1, q[i].v};
    if (mwb && mrd == rs) return {1'b1, mval};
    return 33'd0;
  endfunction

  task automatic model_update();
    logic acc;
    ent_t e;
    if (reset) begin
      q.delete();
      mwb  = 1'b0;
      mrd  = 5'd0;
      mval = 32'd0;
    end else begin
      acc = bus.m_valid && model_ready();
      if (q.size() > 0 && !wr_hold) begin
        e    = q.pop_front();
        mwb  = 1'b1;
        mrd  = e.rd;
        mval = e.v;
      end else begin
        mwb = 1'b0;
      end
      if (acc && bus.m_rd != 5'd0) q.push_back('{bus.m_rd, fmt()});
    end
  endtask

  task automatic compare_all();
    check("m_ready", {32'd0, bus.m_ready}, {32'd0, model_ready()});
    check("WB", {32'd0, WB}, {32'd0, mwb});
    check("Rd", {28'd0, Rd}, {28'd0, mrd});
    check("reg_s", {1'b0, reg_s}, {1'b0, mval});
    check("fwd1", {fwd1_hit, fwd1_data}, model_fwd(fwd_rs1));
    check("fwd2", {fwd2_hit, fwd2_data}, model_fwd(fwd_rs2));
  endtask

  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.m_valid     = 1'b0;
    bus.m_rd        = 5'd0;
    bus.m_is_load   = 1'b0;
    bus.m_ld_size   = 2'b00;
    bus.m_ld_signed = 1'b0;
    bus.m_addr_lo   = 2'b00;
    bus.m_alu       = 32'd0;
    bus.m_mem       = 32'd0;
  endtask

  task automatic push_alu(logic [4:0] rd, logic [31:0] v);
    idle();
    bus.m_valid = 1'b1;
    bus.m_rd    = rd;
    bus.m_alu   = v;
  endtask

  task automatic load_case(string name, logic [1:0] size, logic sgn,
                           logic [1:0] lo, logic [31:0] exp);
    idle();
    bus.m_valid     = 1'b1;
    bus.m_rd        = 5'd7;
    bus.m_is_load   = 1'b1;
    bus.m_ld_size   = size;
    bus.m_ld_signed = sgn;
    bus.m_addr_lo   = lo;
    bus.m_mem       = 32'h80FF_7F01;
    bus.m_alu       = 32'hDEAD_BEEF;
    cycle();
    idle();
    cycle();
    check(name, {1'b0, reg_s}, {1'b0, exp});
  endtask

  initial begin
    reset   = 1'b1;
    wr_hold = 1'b0;
    fwd_rs1 = 5'd0;
    fwd_rs2 = 5'd0;
    mwb     = 1'b0;
    mrd     = 5'd0;
    mval    = 32'd0;
    idle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cycle();
    check("rst_ready", {32'd0, bus.m_ready}, 33'd0);
    check("rst_reg_s", {1'b0, reg_s}, 33'd0);
    reset = 1'b0;

    // ALU path
    push_alu(5'd5, 32'h1234_5678);
    cycle();
    idle();
    cycle();
    check("alu_wb", {32'd0, WB}, 33'd1);
    check("alu_rd", {28'd0, Rd}, 33'd5);
    check("alu_val", {1'b0, reg_s}, {1'b0, 32'h1234_5678});
    cycle();
    check("alu_wb_off", {32'd0, WB}, 33'd0);

    load_case("ld_sb0", 2'b00, 1'b1, 2'd0, 32'hFFFF_FF80);
    load_case("ld_uh2", 2'b01, 1'b0, 2'd2, 32'h0000_7F01);
    load_case("ld_w", 2'b10, 1'b1, 2'd3, 32'h80FF_7F01);
    load_case("ld_ub1", 2'b00, 1'b0, 2'd1, 32'h0000_00FF);
    load_case("ld_sh0", 2'b01, 1'b1, 2'd0, 32'hFFFF_80FF);

    // Full buffer
    wr_hold = 1'b1;
    push_alu(5'd1, 32'h11);
    cycle();
    push_alu(5'd2, 32'h22);
    cycle();
    idle();
    #1 check("full_ready", {32'd0, bus.m_ready}, 33'd0);
    cycle();
    wr_hold = 1'b0;
    cycle();
    check("pop1_wb", {32'd0, WB}, 33'd1);
    check("pop1_rd", {28'd0, Rd}, 33'd1);
    check("pop1_ready", {32'd0, bus.m_ready}, 33'd1);
    cycle();
    check("pop2_wb", {32'd0, WB}, 33'd1);
    check("pop2_rd", {28'd0, Rd}, 33'd2);
    cycle();

    // Forwarding, youngest wins
    wr_hold = 1'b1;
    push_alu(5'd3, 32'hA);
    cycle();
    push_alu(5'd3, 32'hB);
    cycle();
    idle();
    fwd_rs1 = 5'd3;
    fwd_rs2 = 5'd0;
    #1;
    check("fwd1_lit", {fwd1_hit, fwd1_data},
          FWD ? {1'b1, 32'hB} : 33'd0);
    check("fwd2_lit", {fwd2_hit, fwd2_data}, 33'd0);
    wr_hold = 1'b0;
    cycle();
    cycle();
    cycle();
    fwd_rs1 = 5'd0;

    // R0 discard
    push_alu(5'd0, 32'h55);
    cycle();
    idle();
    #1 check("r0_ready", {32'd0, bus.m_ready}, 33'd1);
    cycle();
    check("r0_nowb", {32'd0, WB}, 33'd0);

    // Reset with entries buffered
    wr_hold = 1'b1;
    push_alu(5'd4, 32'h44);
    cycle();
    push_alu(5'd6, 32'h66);
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset   = 1'b0;
    wr_hold = 1'b0;
    #1 check("rst_mid_ready", {32'd0, bus.m_ready}, 33'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_mid_nowb", {32'd0, WB}, 33'd0);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.m_valid     = ($urandom_range(0, 99) < 65);
      bus.m_rd        = 5'($urandom_range(0, 7));
      bus.m_is_load   = $urandom_range(0, 1) == 1;
      bus.m_ld_size   = 2'($urandom_range(0, 3));
      bus.m_ld_signed = $urandom_range(0, 1) == 1;
      bus.m_addr_lo   = 2'($urandom_range(0, 3));
      bus.m_alu       = $urandom;
      bus.m_mem       = $urandom;
      wr_hold         = ($urandom_range(0, 99) < 35);
      reset           = ($urandom_range(0, 99) < 2);
      fwd_rs1         = 5'($urandom_range(0, 7));
      fwd_rs2         = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, writeback buffer entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port m_valid, input, 1, MEM-stage result valid.
REQ-005 SHALL have port m_ready, output, 1, unit can accept a result this cycle.
REQ-006 SHALL have port m_rd, input, 5, destination register number.
REQ-007 SHALL have port m_is_load, input, 1; 1 selects m_mem, 0 selects m_alu.
REQ-008 SHALL have port m_ld_size, input, 2; 00 byte, 01 half, 10/11 word.
REQ-009 SHALL have port m_ld_signed, input, 1; 1 sign-extends, 0 zero-extends.
REQ-010 SHALL have port m_addr_lo, input, 2, low load-address bits.
REQ-011 SHALL have ports m_alu and m_mem, input, 32 each, ALU result and raw memory word.
REQ-012 SHALL have port wr_hold, input, 1; when high, no register-file write is issued.
REQ-013 SHALL have ports WB (output, 1), Rd (output, 5), reg_s (output, 32), driving the register-file write port.
REQ-014 SHALL have ports fwd_rs1 and fwd_rs2, input, 5 each, source registers being read.
REQ-015 SHALL have ports fwd1_hit and fwd2_hit (output, 1) and fwd1_data and fwd2_data (output, 32), bypass results.

Function
REQ-016 SHALL accept a result when m_valid and m_ready are high on a rising edge; m_ready SHALL equal "buffer not full", with no same-cycle pass-through when full.
REQ-017 SHALL format load data big-endian at accept time: byte lane addr_lo 0..3 maps to bits 31:24..7:0; half uses addr_lo[1] (0 maps to 31:16, 1 maps to 15:0); word ignores addr_lo.
REQ-018 SHALL extend byte and half data to 32 bits per m_ld_signed; ignore m_ld_size, m_ld_signed and m_addr_lo when m_is_load=0.
REQ-019 SHALL discard accepted results with m_rd=0: accepted, never stored, no slot consumed.
REQ-020 SHALL store Rd/value in an in-order DEPTH-entry circular buffer with wrapping read/write pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-021 SHALL pop the buffer head on every edge where the buffer is non-empty and wr_hold=0, registering WB=1, Rd=head rd, reg_s=head value; otherwise WB SHALL be registered 0 and Rd/reg_s SHALL hold.
REQ-022 SHALL give latency of exactly 1 cycle: a result accepted at edge N into an empty buffer with wr_hold low at edge N+1 appears with WB=1 after edge N+1.
REQ-023 SHALL, on simultaneous push and pop, leave occupancy unchanged; the pushed entry may not bypass older entries.
REQ-024 SHALL issue WB pulses strictly in acceptance order, one per cycle, one per stored entry.
REQ-025 SHALL compute fwdN_hit/fwdN_data combinationally by matching fwd_rsN against valid buffer entries and the output register when WB=1; the youngest match wins, and the output register is oldest.
REQ-026 SHALL never report a hit for fwd_rsN=0; fwdN_data SHALL be 0 when there is no hit.

Reset
REQ-027 SHALL, while reset is high, empty the buffer, zero the pointers and counter, and drive WB=0, Rd=0, reg_s=0, m_ready=0.
REQ-028 SHALL discard all buffered and in-flight results on reset asserted mid-operation; no WB pulse follows; m_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL compile the bypass logic only when macro WB_UNIT_FWD_EN is defined; without it, fwd1_hit and fwd2_hit are tied 0, fwd1_data and fwd2_data are tied 0, and ports remain present.

Verification
REQ-030 SHALL cover the ALU path: m_rd=5, m_alu=0x12345678, m_is_load=0, hold low -> next cycle WB=1, Rd=5, reg_s=0x12345678, then WB=0.
REQ-031 SHALL cover loads: m_mem=0x80FF7F01; signed byte at addr_lo=0 -> 0xFFFFFF80; unsigned half at addr_lo=2 -> 0x00007F01; word -> 0x80FF7F01.
REQ-032 SHALL cover full buffer: DEPTH=2, wr_hold=1, push rd 1,2 -> m_ready=0; release hold -> WB for Rd 1 then Rd 2 on consecutive cycles, m_ready=1 after first pop.
REQ-033 SHALL cover forwarding with WB_UNIT_FWD_EN: buffer holds rd3=0xA then rd3=0xB, fwd_rs1=3 -> fwd1_hit=1, fwd1_data=0xB; fwd_rs2=0 -> fwd2_hit=0.
REQ-034 SHALL cover R0 discard: push m_rd=0 -> m_ready stays 1, occupancy 0, no WB pulse.
REQ-035 SHALL cover mid-operation reset: two entries buffered with hold high, then reset one cycle -> WB never asserts, m_ready=1 on the cycle after reset drops.
